// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: a Moore FSM that steps each instruction
// through 3-5 cycles and drives the shared-ALU / single-memory datapath.
// Memory accesses wait on mem_ready, bne is optional, and unsupported
// opcodes or functs either trap or are dropped as a NOP.
`timescale 1ns/1ps
module mc_control_unit #(
  parameter int ALUCTRL_W = 3,
  parameter bit EN_BNE    = 1'b1,
  parameter bit EN_TRAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Where an illegal instruction goes: parked in TRAP, or dropped as a NOP.
  localparam state_t S_ILLNEXT = EN_TRAP ? S_TRAP : S_FETCH;

  // 1 when the opcode is one this build can execute.
  function automatic logic op_legal(input logic [5:0] o);
    case (o)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_BNE:  op_legal = EN_BNE;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // R-type funct decode: {valid, alu code}; unknown functs fall back to add.
  function automatic logic [3:0] funct_dec(input logic [5:0] f);
    case (f)
      6'b100000: funct_dec = {1'b1, ALU_ADD};
      6'b100010: funct_dec = {1'b1, ALU_SUB};
      6'b100100: funct_dec = {1'b1, ALU_AND};
      6'b100101: funct_dec = {1'b1, ALU_OR};
      6'b101010: funct_dec = {1'b1, ALU_SLT};
      default:   funct_dec = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t     state_q;
  logic [3:0] fdec_s;
  logic       funct_ok_s;
  logic [2:0] funct_alu_s;

  assign fdec_s      = funct_dec(funct);
  assign funct_ok_s  = fdec_s[3];
  assign funct_alu_s = fdec_s[2:0];

  // State register and transition rules for every instruction class.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_RTYPE:     state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_BNE:       state_q <= EN_BNE ? S_BRANCH : S_ILLNEXT;
            OP_ADDI:      state_q <= S_ADDIEX;
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= S_ILLNEXT;
          endcase
        end
        S_MEMADR: state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  state_q <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   state_q <= funct_ok_s ? S_ALUWB : S_ILLNEXT;
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_TRAP:   state_q <= S_TRAP;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  logic       iord_s, memwrite_s, irwrite_s, regdst_s, memtoreg_s;
  logic       regwrite_s, alusrca_s, pcen_s, illegal_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [2:0] alu_s;

  // Moore output decode; anything a state does not name stays 0.
  always_comb begin
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    pcen_s     = 1'b0;
    alu_s      = 3'b000;
    illegal_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_s = 2'b01;
        alu_s     = ALU_ADD;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        alu_s     = ALU_ADD;
        illegal_s = ~op_legal(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        alu_s     = ALU_ADD;
      end
      S_MEMRD: iord_s = 1'b1;
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXEC: begin
        alusrca_s = 1'b1;
        alu_s     = funct_alu_s;
        illegal_s = ~funct_ok_s;
      end
      S_ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        alu_s     = ALU_SUB;
        pcsrc_s   = 2'b01;
        pcen_s    = (op == OP_BNE) ? ~zero : zero;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc_s = 2'b10;
        pcen_s  = 1'b1;
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
  end

  // While reset is held no strobe may reach the datapath.
  assign irwrite  = irwrite_s  & reset_n;
  assign pcen     = pcen_s     & reset_n;
  assign memwrite = memwrite_s & reset_n;
  assign regwrite = regwrite_s & reset_n;

  assign iord     = iord_s;
  assign regdst   = regdst_s;
  assign memtoreg = memtoreg_s;
  assign alusrca  = alusrca_s;
  assign alusrcb  = alusrcb_s;
  assign pcsrc    = pcsrc_s;
  assign illegal  = illegal_s;
  assign state    = state_q;

  // Upper ALU-control bits are unused by this ALU and held at 0.
  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu_s;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: two builds (full features; no bne / no trap /
// 4-bit ALU control) share one stimulus stream and are checked each cycle
// against an instruction-path model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mc_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  logic       a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite;
  logic       a_alusrca, a_pcen, a_illegal;
  logic [1:0] a_alusrcb, a_pcsrc;
  logic [2:0] a_alucontrol;
  logic [3:0] a_state;

  logic       b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite;
  logic       b_alusrca, b_pcen, b_illegal;
  logic [1:0] b_alusrcb, b_pcsrc;
  logic [3:0] b_alucontrol;
  logic [3:0] b_state;

  mc_control_unit #(.ALUCTRL_W(3), .EN_BNE(1'b1), .EN_TRAP(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(a_iord), .memwrite(a_memwrite),
    .irwrite(a_irwrite), .regdst(a_regdst), .memtoreg(a_memtoreg),
    .regwrite(a_regwrite), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
    .pcsrc(a_pcsrc), .pcen(a_pcen), .alucontrol(a_alucontrol),
    .illegal(a_illegal), .state(a_state));

  mc_control_unit #(.ALUCTRL_W(4), .EN_BNE(1'b0), .EN_TRAP(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(b_iord), .memwrite(b_memwrite),
    .irwrite(b_irwrite), .regdst(b_regdst), .memtoreg(b_memtoreg),
    .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
    .pcsrc(b_pcsrc), .pcen(b_pcen), .alucontrol(b_alucontrol),
    .illegal(b_illegal), .state(b_state));

  logic [20:0] obs_a, obs_b;
  assign obs_a = {a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite,
                  a_alusrca, a_alusrcb, a_pcsrc, a_pcen, 1'b0, a_alucontrol,
                  a_illegal, a_state};
  assign obs_b = {b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
                  b_alusrca, b_alusrcb, b_pcsrc, b_pcen, b_alucontrol,
                  b_illegal, b_state};

  int ntests = 0;
  int nfail  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instance 0 has bne and trap, instance 1 has neither.
  function automatic bit legal_op(input int inst, input logic [5:0] o);
    case (o)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
      6'b000101: return (inst == 0);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [23:0] mk(input int n, input int s0, input int s1,
                                     input int s2, input int s3, input int s4);
    return {4'(n), 4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
  endfunction

  // Full state path of one instruction: {length, s4..s0}.
  function automatic logic [23:0] path(input int inst, input logic [5:0] o, input logic [5:0] f);
    bit tr;
    tr = (inst == 0);
    if (!legal_op(inst, o)) return tr ? mk(3, 0, 1, 12, 0, 0) : mk(2, 0, 1, 0, 0, 0);
    case (o)
      6'b000000: begin
        if (funct_ok(f)) return mk(4, 0, 1, 6, 7, 0);
        return tr ? mk(4, 0, 1, 6, 12, 0) : mk(3, 0, 1, 6, 0, 0);
      end
      6'b100011: return mk(5, 0, 1, 2, 3, 4);
      6'b101011: return mk(4, 0, 1, 2, 5, 0);
      6'b001000: return mk(4, 0, 1, 9, 10, 0);
      6'b000010: return mk(3, 0, 1, 11, 0, 0);
      default:   return mk(3, 0, 1, 8, 0, 0);
    endcase
  endfunction

  function automatic int mstate(input int inst, input logic [3:0] step, input bit trap,
                                input logic [5:0] o, input logic [5:0] f);
    logic [23:0] p;
    if (trap) return 12;
    p = path(inst, o, f);
    return int'(p[4*step +: 4]);
  endfunction

  // Next {trap, step}: memory states wait for mem_ready, paths wrap to FETCH.
  function automatic logic [4:0] nxt(input int inst, input logic [3:0] step, input bit trap,
                                     input logic [5:0] o, input logic [5:0] f, input logic mr);
    logic [23:0] p;
    int cs, ns;
    if (trap) return {1'b1, step};
    p  = path(inst, o, f);
    cs = int'(p[4*step +: 4]);
    if ((cs == 0 || cs == 3 || cs == 5) && !mr) return {1'b0, step};
    ns = int'(step) + 1;
    if (ns >= int'(p[23:20])) return 5'd0;
    return {p[4*ns +: 4] == 4'd12, 4'(ns)};
  endfunction

  function automatic logic [20:0] expv(input int s, input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input logic mr, input logic rn,
                                       input int inst);
    logic iord_e, mw, irw, rd, m2r, rw, asa, pce, ill;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {iord_e, mw, irw, rd, m2r, rw, asa, pce, ill} = 9'd0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (s)
      0:  begin asb = 2'b01; alu = 3'b010; irw = mr; pce = mr; end
      1:  begin asb = 2'b11; alu = 3'b010; ill = !legal_op(inst, o); end
      2:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
      3:  iord_e = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin iord_e = 1'b1; mw = 1'b1; end
      6:  begin
        asa = 1'b1;
        case (f)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   begin alu = 3'b010; ill = 1'b1; end
        endcase
      end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; alu = 3'b110; pcs = 2'b01; pce = (o == 6'b000101) ? !z : z; end
      9:  begin asa = 1'b1; asb = 2'b10; alu = 3'b010; end
      10: rw = 1'b1;
      11: begin pcs = 2'b10; pce = 1'b1; end
      12: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    if (!rn) begin irw = 1'b0; pce = 1'b0; mw = 1'b0; rw = 1'b0; end
    return {iord_e, mw, irw, rd, m2r, rw, asa, asb, pcs, pce, 1'b0, alu, ill, 4'(s)};
  endfunction

  logic [3:0] m_step0 = 4'd0, m_step1 = 4'd0;
  bit         m_trap0 = 1'b0, m_trap1 = 1'b0;

  // Model advance on each clock; reset returns both instances to FETCH.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_step0 <= 4'd0; m_trap0 <= 1'b0;
      m_step1 <= 4'd0; m_trap1 <= 1'b0;
    end else begin
      {m_trap0, m_step0} <= nxt(0, m_step0, m_trap0, op, funct, mem_ready);
      {m_trap1, m_step1} <= nxt(1, m_step1, m_trap1, op, funct, mem_ready);
    end
  end

  // Per-cycle comparison of every output of both instances.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_a", 32'(obs_a),
          32'(expv(mstate(0, m_step0, m_trap0, op, funct), op, funct, zero, mem_ready, reset_n, 0)));
      chk("cycle_b", 32'(obs_b),
          32'(expv(mstate(1, m_step1, m_trap1, op, funct), op, funct, zero, mem_ready, reset_n, 1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b1; op = 6'd0; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset held for three cycles.
    repeat (3) cyc(1'b1);
    chk("rst_state_a", a_state, 4'd0);
    chk("rst_pcen_a", a_pcen, 1'b0);
    chk("rst_irwrite_a", a_irwrite, 1'b0);
    chk("rst_state_b", b_state, 4'd0);
    chk("rst_alusrcb_a", a_alusrcb, 2'b01);
    reset_n = 1'b1;
    #1;
    chk("post_rst_irwrite", a_irwrite, 1'b1);

    // lw with mem_ready high: 0,1,2,3,4,0.
    op = 6'b100011;
    cyc(1'b1); chk("lw_s1", a_state, 4'd1);
    cyc(1'b1); chk("lw_s2", a_state, 4'd2);
    cyc(1'b1); chk("lw_s3", a_state, 4'd3); chk("lw_iord", a_iord, 1'b1);
               chk("lw_rw_s3", a_regwrite, 1'b0);
    cyc(1'b1); chk("lw_s4", a_state, 4'd4); chk("lw_rw", a_regwrite, 1'b1);
               chk("lw_m2r", a_memtoreg, 1'b1);
    cyc(1'b1); chk("lw_done", a_state, 4'd0); chk("lw_rw_after", a_regwrite, 1'b0);

    // sw with one FETCH stall and two MEMWR stalls.
    op = 6'b101011;
    mem_ready = 1'b0;
    #1; chk("fetch_stall_irw", a_irwrite, 1'b0);
    cyc(1'b1); chk("fetch_stall_s", a_state, 4'd0); chk("fetch_irw", a_irwrite, 1'b1);
    cyc(1'b1); chk("sw_s1", a_state, 4'd1);
    cyc(1'b1); chk("sw_s2", a_state, 4'd2);
    cyc(1'b0); chk("sw_mw0", a_memwrite, 1'b1); chk("sw_rw0", a_regwrite, 1'b0);
    cyc(1'b0); chk("sw_mw1", a_memwrite, 1'b1); chk("sw_s5", a_state, 4'd5);
    cyc(1'b1); chk("sw_mw2", a_memwrite, 1'b1); chk("sw_rw2", a_regwrite, 1'b0);
    cyc(1'b1); chk("sw_done", a_state, 4'd0); chk("sw_mw_off", a_memwrite, 1'b0);

    // R-type slt.
    op = 6'b000000; funct = 6'b101010;
    cyc(1'b1);
    cyc(1'b1); chk("slt_alu_a", a_alucontrol, 3'b111); chk("slt_alu_b", b_alucontrol, 4'b0111);
    cyc(1'b1); chk("slt_regdst", a_regdst, 1'b1); chk("slt_rw", a_regwrite, 1'b1);
    cyc(1'b1); chk("slt_done", a_state, 4'd0);

    // beq taken then not taken.
    op = 6'b000100; zero = 1'b1;
    cyc(1'b1);
    cyc(1'b1); chk("beq_t_pcen", a_pcen, 1'b1); chk("beq_pcsrc", a_pcsrc, 2'b01);
    cyc(1'b1); zero = 1'b0;
    cyc(1'b1);
    cyc(1'b1); chk("beq_nt_pcen", a_pcen, 1'b0); chk("beq_nt_s", a_state, 4'd8);
    cyc(1'b1);

    // bne: taken on instance a, illegal NOP on instance b.
    op = 6'b000101; zero = 1'b0;
    cyc(1'b1); chk("bne_ill_b", b_illegal, 1'b1); chk("bne_ill_a", a_illegal, 1'b0);
    cyc(1'b1); chk("bne_pcen", a_pcen, 1'b1); chk("bne_b_fetch", b_state, 4'd0);
    cyc(1'b1);
    do_reset();
    zero = 1'b1;
    cyc(1'b1);
    cyc(1'b1); chk("bne_nt_pcen", a_pcen, 1'b0);
    cyc(1'b1);
    do_reset();

    // addi and j.
    op = 6'b001000;
    cyc(1'b1);
    cyc(1'b1); chk("addi_asb", a_alusrcb, 2'b10); chk("addi_s", a_state, 4'd9);
    cyc(1'b1); chk("addi_rw", a_regwrite, 1'b1);
    cyc(1'b1);
    op = 6'b000010;
    cyc(1'b1);
    cyc(1'b1); chk("j_pcsrc", a_pcsrc, 2'b10); chk("j_pcen", a_pcen, 1'b1);
    cyc(1'b1); chk("j_done", a_state, 4'd0);

    // Illegal opcode: trap on a, one-cycle pulse on b.
    op = 6'b111111;
    cyc(1'b1); chk("ill_dec_a", a_illegal, 1'b1); chk("ill_dec_b", b_illegal, 1'b1);
    cyc(1'b1); chk("ill_trap_a", a_state, 4'd12); chk("ill_b_fetch", b_state, 4'd0);
               chk("ill_b_pulse", b_illegal, 1'b0);
    do_reset();

    // Illegal funct: trap holds for ten cycles.
    op = 6'b000000; funct = 6'b000000;
    cyc(1'b1);
    cyc(1'b1); chk("badf_ill", a_illegal, 1'b1); chk("badf_alu", a_alucontrol, 3'b010);
               chk("badf_rw", a_regwrite, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      chk("trap_hold", a_state, 4'd12);
    end
    do_reset();

    // Reset asserted during MEMWB aborts the write at once.
    op = 6'b100011; funct = 6'b100000;
    repeat (4) cyc(1'b1);
    chk("wb_rw", a_regwrite, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_rw", a_regwrite, 1'b0); chk("abort_s", a_state, 4'd0);
    chk("abort_rw_b", b_regwrite, 1'b0);
    cyc(1'b1);
    reset_n = 1'b1;
    cyc(1'b1);
    chk("restart_s", a_state, 4'd1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
